fpcvt_pipe: RTL and testbench

- Pipelined, parametrised converter from a signed two's-complement integer to a compact sign/exponent/significand float: value = (-1)^sign * significand * 2^exponent.
- Generalises the combinational 12-bit to (3-bit exponent, 4-bit significand) converter. Adds configurable widths, runtime rounding mode, saturation/inexact flags and a valid/ready streaming interface with backpressure.
- Sits between sample producers (ADC/accumulator paths) and compressed-storage or transmit logic.

---
 rtl/fpcvt_if.sv | 31 +++
 rtl/fpcvt_pipe.sv | 188 ++++++++++++++++++
 tb/tb_fpcvt_pipe.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpcvt_if.sv
// Streaming bus for the integer-to-float converter: input word handshake on
// one side, packed float result with status flags on the other.
interface fpcvt_if #(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int SIG_W = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             round_en;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [EXP_W-1:0] out_exp;
  logic [SIG_W-1:0] out_sig;
  logic             out_sat;
  logic             out_inexact;

  // Converter side
  modport slave (
    input  in_valid, in_data, round_en, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_sig, out_sat, out_inexact
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_data, round_en, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_sig, out_sat, out_inexact
  );
endinterface

// File: rtl/fpcvt_pipe.sv
// Three-stage pipelined converter from a signed integer to a sign/exponent/
// significand float (value = significand * 2^exponent), with optional
// round-half-up, saturation and inexact flags, and valid/ready backpressure.
module fpcvt_pipe #(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int SIG_W = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  fpcvt_if.slave bus
);
  localparam int M    = IN_W - 1;
  localparam int EMAX = (1 << EXP_W) - 1;

  // The exponent field must exactly cover every shift a magnitude can need.
  generate
    if (M - SIG_W != EMAX) begin : g_bad_params
      $error("fpcvt_pipe: IN_W-1-SIG_W must equal 2**EXP_W-1");
    end
  endgenerate

  // Stage valids and per-stage load enables
  logic v1_q, v2_q, v3_q;
  logic rdy1_s, rdy2_s, rdy3_s;

  // Stage 1: sign / magnitude
  logic         s1_sign_d, s1_sign_q;
  logic         s1_sat_d, s1_sat_q;
  logic         s1_rnd_q;
  logic [M-1:0] s1_mag_d, s1_mag_q;
  logic [M-1:0] neg_s;

  // Stage 2: normalised fields
  int               lead_s;
  int               shift_s;
  logic [EXP_W-1:0] s2_exp_d, s2_exp_q;
  logic [SIG_W-1:0] s2_sig_d, s2_sig_q;
  logic             s2_rbit_d, s2_rbit_q;
  logic             s2_sticky_d, s2_sticky_q;
  logic             s2_sign_q, s2_sat_q, s2_rnd_q;

  // Stage 3: rounded / saturated result
  logic [SIG_W:0]   sum_s;
  logic [SIG_W-1:0] sig_rnd_s;
  logic [EXP_W:0]   exp_inc_s;
  logic [EXP_W-1:0] out_exp_d, out_exp_q;
  logic [SIG_W-1:0] out_sig_d, out_sig_q;
  logic             out_sat_d, out_sat_q;
  logic             out_sign_q, out_inexact_q;

  // A stage may load when it is empty or the stage after it is moving on.
  always_comb begin
    rdy3_s = !v3_q || bus.out_ready;
    rdy2_s = !v2_q || rdy3_s;
    rdy1_s = !v1_q || rdy2_s;
  end

  // Sign/magnitude split; the most-negative input has no positive twin, so
  // it is clamped to the largest magnitude and flagged as saturated.
  always_comb begin
    neg_s     = {M{1'b0}} - bus.in_data[M-1:0];
    s1_sign_d = bus.in_data[IN_W-1];
    if (bus.in_data == {1'b1, {M{1'b0}}}) begin
      s1_mag_d = {M{1'b1}};
      s1_sat_d = 1'b1;
    end else if (s1_sign_d) begin
      s1_mag_d = neg_s;
      s1_sat_d = 1'b0;
    end else begin
      s1_mag_d = bus.in_data[M-1:0];
      s1_sat_d = 1'b0;
    end
  end

  // Stage 1 register; round_en is captured with its word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_sat_q  <= 1'b0;
      s1_rnd_q  <= 1'b0;
      s1_mag_q  <= {M{1'b0}};
    end else if (rdy1_s) begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign_q <= s1_sign_d;
        s1_sat_q  <= s1_sat_d;
        s1_rnd_q  <= bus.round_en;
        s1_mag_q  <= s1_mag_d;
      end
    end
  end

  // Leading-one search, then pick the SIG_W-bit window below it plus the
  // first discarded bit (round) and the OR of all discarded bits (sticky).
  always_comb begin
    lead_s = 0;
    for (int i = 0; i < M; i++) begin
      lead_s = s1_mag_q[i] ? i : lead_s;
    end
    shift_s     = (lead_s >= SIG_W) ? (lead_s - SIG_W + 1) : 0;
    s2_exp_d    = EXP_W'(shift_s);
    s2_sig_d    = SIG_W'(s1_mag_q >> shift_s);
    s2_rbit_d   = 1'b0;
    s2_sticky_d = 1'b0;
    for (int i = 0; i < M; i++) begin
      s2_rbit_d   = (i == shift_s - 1) ? s1_mag_q[i] : s2_rbit_d;
      s2_sticky_d = s2_sticky_d | (s1_mag_q[i] & (i < shift_s));
    end
  end

  // Stage 2 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q        <= 1'b0;
      s2_exp_q    <= {EXP_W{1'b0}};
      s2_sig_q    <= {SIG_W{1'b0}};
      s2_rbit_q   <= 1'b0;
      s2_sticky_q <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_sat_q    <= 1'b0;
      s2_rnd_q    <= 1'b0;
    end else if (rdy2_s) begin
      v2_q <= v1_q;
      if (v1_q) begin
        s2_exp_q    <= s2_exp_d;
        s2_sig_q    <= s2_sig_d;
        s2_rbit_q   <= s2_rbit_d;
        s2_sticky_q <= s2_sticky_d;
        s2_sign_q   <= s1_sign_q;
        s2_sat_q    <= s1_sat_q;
        s2_rnd_q    <= s1_rnd_q;
      end
    end
  end

  // Round half-up; a carry out of the significand renormalises to 100..0
  // with the exponent bumped, and an exponent overflow saturates to all ones.
  always_comb begin
    sum_s = {1'b0, s2_sig_q} + {{SIG_W{1'b0}}, s2_rnd_q & s2_rbit_q};
    if (sum_s[SIG_W]) begin
      sig_rnd_s = {1'b1, {(SIG_W-1){1'b0}}};
      exp_inc_s = {1'b0, s2_exp_q} + {{EXP_W{1'b0}}, 1'b1};
    end else begin
      sig_rnd_s = sum_s[SIG_W-1:0];
      exp_inc_s = {1'b0, s2_exp_q};
    end
    if (exp_inc_s[EXP_W]) begin
      out_exp_d = {EXP_W{1'b1}};
      out_sig_d = {SIG_W{1'b1}};
      out_sat_d = 1'b1;
    end else begin
      out_exp_d = exp_inc_s[EXP_W-1:0];
      out_sig_d = sig_rnd_s;
      out_sat_d = s2_sat_q;
    end
  end

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q          <= 1'b0;
      out_sign_q    <= 1'b0;
      out_exp_q     <= {EXP_W{1'b0}};
      out_sig_q     <= {SIG_W{1'b0}};
      out_sat_q     <= 1'b0;
      out_inexact_q <= 1'b0;
    end else if (rdy3_s) begin
      v3_q <= v2_q;
      if (v2_q) begin
        out_sign_q    <= s2_sign_q;
        out_exp_q     <= out_exp_d;
        out_sig_q     <= out_sig_d;
        out_sat_q     <= out_sat_d;
        out_inexact_q <= s2_sticky_q;
      end
    end
  end

  assign bus.in_ready    = rdy1_s;
  assign bus.out_valid   = v3_q;
  assign bus.out_sign    = out_sign_q;
  assign bus.out_exp     = out_exp_q;
  assign bus.out_sig     = out_sig_q;
  assign bus.out_sat     = out_sat_q;
  assign bus.out_inexact = out_inexact_q;
endmodule

// File: tb/tb_fpcvt_pipe.sv
// Scoreboard bench for fpcvt_pipe: a driver pushes the expected result of
// each accepted word, monitors pop and compare on every output transfer.
module tb_fpcvt_pipe;
  typedef struct packed {
    logic       sign;
    logic [7:0] ex;
    logic [7:0] sg;
    logic       sat;
    logic       inx;
  } res_t;

  typedef struct packed {
    logic [31:0] d;
    logic        r;
    res_t        e;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_acc = -1;
  int first_out = -1;
  int last_out = -1;
  int acc_cnt = 0;
  res_t sb_a[$];
  res_t sb_b[$];
  vec_t send_a[$];
  vec_t va[$];
  vec_t vb[$];

  fpcvt_if #(.IN_W(12), .EXP_W(3), .SIG_W(4)) ifa ();
  fpcvt_if #(.IN_W(20), .EXP_W(4), .SIG_W(4)) ifb ();

  fpcvt_pipe #(.IN_W(12), .EXP_W(3), .SIG_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  fpcvt_pipe #(.IN_W(20), .EXP_W(4), .SIG_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(int d, bit r, bit s, int e, int g, bit sat, bit inx);
    vec_t v;
    v.d = d;
    v.r = r;
    v.e.sign = s;
    v.e.ex = 8'(e);
    v.e.sg = 8'(g);
    v.e.sat = sat;
    v.e.inx = inx;
    return v;
  endfunction

  function automatic res_t got_a();
    return {ifa.out_sign, 8'(ifa.out_exp), 8'(ifa.out_sig), ifa.out_sat, ifa.out_inexact};
  endfunction

  function automatic res_t got_b();
    return {ifb.out_sign, 8'(ifb.out_exp), 8'(ifb.out_sig), ifb.out_sat, ifb.out_inexact};
  endfunction

  task automatic check(string name, res_t got, res_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got s=%0b e=%0d g=%b sat=%0b inx=%0b want s=%0b e=%0d g=%b sat=%0b inx=%0b",
               name, got.sign, got.ex, got.sg[3:0], got.sat, got.inx,
               want.sign, want.ex, want.sg[3:0], want.sat, want.inx);
    end
  endtask

  task automatic check_int(string name, int got, int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic wait_drain(string name, int budget);
    int n;
    n = 0;
    while ((send_a.size() != 0 || sb_a.size() != 0 || sb_b.size() != 0) && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s timeout got pending %0d/%0d/%0d want 0", name,
               send_a.size(), sb_a.size(), sb_b.size());
    end
  endtask

  // Driver for the 12-bit instance: presents the head of send_a and records
  // the expected result on each accepted transfer.
  initial begin
    bit acc;
    ifa.in_valid  = 1'b0;
    ifa.in_data   = 12'd0;
    ifa.round_en  = 1'b0;
    ifa.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      acc = rst_n && ifa.in_valid && ifa.in_ready;
      if (acc) begin
        sb_a.push_back(send_a[0].e);
        acc_cnt++;
        if (first_acc < 0) first_acc = cyc;
      end
      @(posedge clk);
      #1;
      if (acc) void'(send_a.pop_front());
      if (send_a.size() > 0) begin
        ifa.in_valid = 1'b1;
        ifa.in_data  = send_a[0].d[11:0];
        ifa.round_en = send_a[0].r;
      end else begin
        ifa.in_valid = 1'b0;
      end
    end
  end

  // Monitor for the 12-bit instance
  initial forever begin
    @(negedge clk);
    if (rst_n && ifa.out_valid) begin
      if (first_out < 0) first_out = cyc;
      if (ifa.out_ready) begin
        last_out = cyc;
        if (sb_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected got output e=%0d g=%b want none", ifa.out_exp, ifa.out_sig);
        end else begin
          check("a_result", got_a(), sb_a.pop_front());
        end
      end
    end
  end

  // Monitor for the 20-bit instance
  initial forever begin
    @(negedge clk);
    if (rst_n && ifb.out_valid && ifb.out_ready) begin
      if (sb_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected got output e=%0d g=%b want none", ifb.out_exp, ifb.out_sig);
      end else begin
        check("b_result", got_b(), sb_b.pop_front());
      end
    end
  end

  initial begin
    int base;
    int n;
    ifb.in_valid  = 1'b0;
    ifb.in_data   = 20'd0;
    ifb.round_en  = 1'b0;
    ifb.out_ready = 1'b1;

    //      data   rnd sign exp sig sat inx
    va.push_back(mk(15,    1, 0, 0, 15, 0, 0));
    va.push_back(mk(15,    0, 0, 0, 15, 0, 0));
    va.push_back(mk(125,   1, 0, 4,  8, 0, 1));
    va.push_back(mk(125,   0, 0, 3, 15, 0, 1));
    va.push_back(mk(2047,  1, 0, 7, 15, 1, 1));
    va.push_back(mk(2047,  0, 0, 7, 15, 0, 1));
    va.push_back(mk(-2048, 1, 1, 7, 15, 1, 1));
    va.push_back(mk(-2048, 0, 1, 7, 15, 1, 1));
    va.push_back(mk(0,     1, 0, 0,  0, 0, 0));
    va.push_back(mk(-7,    1, 1, 0,  7, 0, 0));
    va.push_back(mk(29,    1, 0, 1, 15, 0, 1));
    va.push_back(mk(29,    0, 0, 1, 14, 0, 1));
    va.push_back(mk(31,    1, 0, 2,  8, 0, 1));
    va.push_back(mk(-100,  0, 1, 3, 12, 0, 1));
    va.push_back(mk(-100,  1, 1, 3, 13, 0, 1));
    va.push_back(mk(1024,  1, 0, 7,  8, 0, 0));
    va.push_back(mk(1152,  1, 0, 7,  9, 0, 0));
    va.push_back(mk(1088,  1, 0, 7,  9, 0, 1));
    va.push_back(mk(1983,  1, 0, 7, 15, 0, 1));
    va.push_back(mk(1,     0, 0, 0,  1, 0, 0));
    va.push_back(mk(-1,    1, 1, 0,  1, 0, 0));

    vb.push_back(mk(278528,  0, 0, 15,  8, 0, 1));
    vb.push_back(mk(278528,  1, 0, 15,  9, 0, 1));
    vb.push_back(mk(524287,  1, 0, 15, 15, 1, 1));
    vb.push_back(mk(-524288, 0, 1, 15, 15, 1, 1));
    vb.push_back(mk(20,      1, 0,  1, 10, 0, 0));

    // Reset state
    #12;
    check_int("rst_valid_a", int'(ifa.out_valid), 0);
    check("rst_outputs_a", got_a(), '0);
    check_int("rst_valid_b", int'(ifb.out_valid), 0);
    check("rst_outputs_b", got_b(), '0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check_int("in_ready_after_rst", int'(ifa.in_ready), 1);

    // Back-to-back directed stream
    foreach (va[i]) send_a.push_back(va[i]);
    wait_drain("stream_drain", 200);
    check_int("latency_cycles", first_out - first_acc, 3);
    check_int("one_per_cycle", last_out - first_out, va.size() - 1);

    // Backpressure: consumer stalls while six words are offered
    ifa.out_ready = 1'b0;
    base = acc_cnt;
    for (int i = 0; i < 6; i++) send_a.push_back(va[i + 2]);
    repeat (8) @(negedge clk);
    check_int("bp_accepted", acc_cnt - base, 3);
    check_int("bp_in_ready_low", int'(ifa.in_ready), 0);
    check_int("bp_out_valid", int'(ifa.out_valid), 1);
    repeat (5) begin
      @(negedge clk);
      check("bp_hold", got_a(), sb_a[0]);
      check_int("bp_in_ready_held", int'(ifa.in_ready), 0);
    end
    @(posedge clk);
    #2;
    ifa.out_ready = 1'b1;
    wait_drain("bp_drain", 200);
    check_int("bp_total_accepted", acc_cnt - base, 6);

    // Reset with three words in flight
    send_a.push_back(va[2]);
    send_a.push_back(va[11]);
    send_a.push_back(va[9]);
    n = 0;
    while (send_a.size() != 0 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    check_int("inflight_count", sb_a.size(), 3);
    check_int("inflight_valid", int'(ifa.out_valid), 1);
    rst_n = 1'b0;
    #1;
    check_int("midrst_valid", int'(ifa.out_valid), 0);
    check("midrst_outputs", got_a(), '0);
    sb_a.delete();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    send_a.push_back(va[15]);
    send_a.push_back(va[13]);
    wait_drain("post_rst_drain", 100);
    repeat (6) @(negedge clk);

    // Wider configuration
    @(posedge clk);
    #2;
    foreach (vb[i]) begin
      ifb.in_valid = 1'b1;
      ifb.in_data  = vb[i].d[19:0];
      ifb.round_en = vb[i].r;
      @(negedge clk);
      check_int("b_in_ready", int'(ifb.in_ready), 1);
      sb_b.push_back(vb[i].e);
      @(posedge clk);
      #2;
    end
    ifb.in_valid = 1'b0;
    wait_drain("b_drain", 100);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
